// File: rtl/mips_bus_pkg.sv
// rtl/mips_bus_pkg.sv - shared types and widths for the MIPS bus arbiter
package mips_bus_pkg;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    function automatic owner_t state_owner(input arb_state_t s);
        case (s)
            GNT_I:   return OWN_I;
            GNT_D:   return OWN_D;
            default: return OWN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// rtl/mips_bus_watchdog.sv - saturating stall counter that flags an abort on the MAX_WAIT-th stall
module mips_bus_watchdog #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    generate
        if (MAX_WAIT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (enable && cnt != LIMIT) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end

            // Fires in the stalled cycle that would bring the count to MAX_WAIT.
            assign expire = enable && (cnt == LIMIT - CNT_W'(1));
        end
    endgenerate

endmodule

// File: rtl/mips_bus_arbiter.sv
// rtl/mips_bus_arbiter.sv - round-robin arbiter sharing one Avalon-style bus between fetch and load/store
module mips_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W   = BUS_ADDR_W,
    parameter int DATA_W   = BUS_DATA_W,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic                i_read,
    output logic                i_waitrequest,
    output logic [DATA_W-1:0]   i_readdata,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_writedata,
    input  logic [DATA_W/8-1:0] d_byteenable,
    output logic                d_waitrequest,
    output logic [DATA_W-1:0]   d_readdata,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    output logic [1:0]          owner,
    output logic                timeout_err
);

    arb_state_t state;
    owner_t     last;
    logic       rq_i, rq_d, own_rq, stall, done, expire;

    assign rq_i = i_read;
    assign rq_d = d_read | d_write;

    always_comb begin
        own_rq = 1'b0;
        case (state)
            GNT_I:   own_rq = rq_i;
            GNT_D:   own_rq = rq_d;
            default: own_rq = 1'b0;
        endcase
    end

    assign stall = own_rq & m_waitrequest;
    assign done  = own_rq & ~m_waitrequest;

    mips_bus_watchdog #(.MAX_WAIT(MAX_WAIT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE || done),
        .enable (stall),
        .expire (expire)
    );

    // The completing master's request is stale in its completion cycle, so only the other side may follow directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            last  <= OWN_D;
        end else begin
            case (state)
                IDLE: begin
                    if (rq_i && (!rq_d || last == OWN_D)) state <= GNT_I;
                    else if (rq_d)                        state <= GNT_D;
                end
                GNT_I: begin
                    if (!rq_i) begin
                        state <= IDLE;
                    end else if (done) begin
                        last  <= OWN_I;
                        state <= rq_d ? GNT_D : IDLE;
                    end else if (expire) begin
                        last  <= OWN_I;
                        state <= IDLE;
                    end
                end
                GNT_D: begin
                    if (!rq_d) begin
                        state <= IDLE;
                    end else if (done) begin
                        last  <= OWN_D;
                        state <= rq_i ? GNT_I : IDLE;
                    end else if (expire) begin
                        last  <= OWN_D;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        m_address     = '0;
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_writedata   = '0;
        m_byteenable  = '0;
        i_waitrequest = 1'b1;
        i_readdata    = '0;
        d_waitrequest = 1'b1;
        d_readdata    = '0;
        case (state)
            GNT_I: begin
                m_address     = i_address;
                m_read        = ~expire;
                m_byteenable  = '1;
                i_waitrequest = m_waitrequest & ~expire;
                i_readdata    = expire ? '0 : m_readdata;
            end
            GNT_D: begin
                m_address     = d_address;
                m_write       = d_write & ~expire;
                m_read        = d_read & ~d_write & ~expire;
                m_writedata   = d_writedata;
                m_byteenable  = d_byteenable;
                d_waitrequest = m_waitrequest & ~expire;
                d_readdata    = expire ? '0 : m_readdata;
            end
            default: ;
        endcase
    end

    assign timeout_err = expire;
    assign owner       = state_owner(state);

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// tb/tb_mips_bus_arbiter.sv - self-checking bench for mips_bus_arbiter
module tb_mips_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MW = 4;

    localparam logic [AW-1:0] IA = 32'h0000_0100;
    localparam logic [AW-1:0] DA = 32'h0000_0200;
    localparam logic [DW-1:0] WD = 32'h1234_5678;
    localparam logic [BW-1:0] BE = 4'b0011;
    localparam logic [DW-1:0] RD = 32'hA5A5_0001;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] i_address, d_address, m_address;
    logic          i_read, i_waitrequest, d_read, d_write, d_waitrequest;
    logic [DW-1:0] i_readdata, d_writedata, d_readdata, m_writedata, m_readdata;
    logic [BW-1:0] d_byteenable, m_byteenable;
    logic          m_read, m_write, m_waitrequest, timeout_err;
    logic [1:0]    owner;

    always #5 clk = ~clk;

    mips_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .i_address(i_address), .i_read(i_read), .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
        .d_byteenable(d_byteenable), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .owner(owner), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [AW-1:0] m_address;
        logic          m_read;
        logic          m_write;
        logic [DW-1:0] m_writedata;
        logic [BW-1:0] m_byteenable;
        logic          i_wait;
        logic [DW-1:0] i_rdata;
        logic          d_wait;
        logic [DW-1:0] d_rdata;
        logic [1:0]    owner;
        logic          terr;
    } out_t;

    typedef struct {
        logic       i_rd, d_rd, d_wr, m_wt;
        logic [1:0] owner;
        logic       m_rd, m_wr, i_wt, d_wt;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_address = IA; i_read = 1'b0;
        d_address = DA; d_read = 1'b0; d_write = 1'b0;
        d_writedata = WD; d_byteenable = BE;
        m_waitrequest = 1'b0; m_readdata = RD;
    endtask

    // Hold reset over an edge, then release just after an edge so the next edge is the first active one.
    task automatic start_reset();
        reset = 1'b0;
        to_pos();
        reset = 1'b1;
    endtask

    function automatic out_t actual();
        out_t a;
        a.m_address = m_address; a.m_read = m_read; a.m_write = m_write;
        a.m_writedata = m_writedata; a.m_byteenable = m_byteenable;
        a.i_wait = i_waitrequest; a.i_rdata = i_readdata;
        a.d_wait = d_waitrequest; a.d_rdata = d_readdata;
        a.owner = owner; a.terr = timeout_err;
        return a;
    endfunction

    // Reference model: who holds the bus (0 none, 1 I, 2 D), who was served last, stalls seen in this grant.
    int   mo, ml, ms, nmo, nml, nms;
    out_t e;

    task automatic model_eval();
        bit rq[3];
        bit req_own, ab;
        rq[0] = 1'b0;
        rq[1] = i_read;
        rq[2] = d_read | d_write;
        e = '0;
        e.i_wait = 1'b1;
        e.d_wait = 1'b1;
        e.owner  = 2'(mo);
        req_own = rq[mo];
        ab = (mo != 0) && req_own && m_waitrequest && (ms + 1 == MW);
        if (mo == 1) begin
            e.m_address = i_address; e.m_read = !ab; e.m_byteenable = '1;
            e.i_wait = ab ? 1'b0 : m_waitrequest;
            e.i_rdata = ab ? '0 : m_readdata;
        end else if (mo == 2) begin
            e.m_address = d_address; e.m_writedata = d_writedata; e.m_byteenable = d_byteenable;
            e.m_write = d_write && !ab;
            e.m_read = d_read && !d_write && !ab;
            e.d_wait = ab ? 1'b0 : m_waitrequest;
            e.d_rdata = ab ? '0 : m_readdata;
        end
        e.terr = ab;
        nmo = mo; nml = ml; nms = ms;
        if (mo == 0) begin
            nms = 0;
            if (rq[1] && rq[2]) nmo = 3 - ml;
            else if (rq[1])     nmo = 1;
            else if (rq[2])     nmo = 2;
        end else if (!req_own) begin
            nmo = 0;
        end else if (!m_waitrequest) begin
            nml = mo;
            nmo = rq[3 - mo] ? 3 - mo : 0;
            nms = 0;
        end else if (ab) begin
            nml = mo;
            nmo = 0;
        end else begin
            nms = ms + 1;
        end
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1, 0, 1, 0, 2'd0, 0, 0, 1, 1};
        tbl[1] = '{1, 0, 1, 0, 2'd1, 1, 0, 0, 1};
        tbl[2] = '{1, 0, 1, 0, 2'd2, 0, 1, 1, 0};
        tbl[3] = '{1, 0, 1, 0, 2'd1, 1, 0, 0, 1};
        tbl[4] = '{1, 0, 1, 0, 2'd2, 0, 1, 1, 0};
        tbl[5] = '{1, 0, 1, 0, 2'd1, 1, 0, 0, 1};
        tbl[6] = '{0, 1, 1, 0, 2'd2, 0, 1, 1, 0};
        tbl[7] = '{0, 1, 1, 0, 2'd0, 0, 0, 1, 1};
        tbl[8] = '{0, 1, 1, 0, 2'd2, 0, 1, 1, 0};

        // Reset held with a pending fetch, then a single zero-wait read.
        reset = 1'b0;
        clear_inputs();
        i_read = 1'b1; i_address = 32'h0000_0010; m_readdata = 32'hCAFE_F00D;
        to_pos();
        to_pos();
        @(negedge clk);
        chk("rst_m_read", 160'(m_read), 160'(1'b0));
        chk("rst_i_wait", 160'(i_waitrequest), 160'(1'b1));
        chk("rst_owner", 160'(owner), 160'(2'd0));
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("release_idle_owner", 160'(owner), 160'(2'd0));
        to_pos();
        @(negedge clk);
        chk("read_grant", 160'({owner, m_read, m_address}), 160'({2'd1, 1'b1, 32'h0000_0010}));
        chk("read_data", 160'({i_waitrequest, i_readdata}), 160'({1'b0, 32'hCAFE_F00D}));
        to_pos();
        @(negedge clk);
        chk("read_bubble_owner", 160'(owner), 160'(2'd0));

        // Contention vectors, then write-wins with both d_read and d_write high.
        clear_inputs();
        start_reset();
        for (int i = 0; i < 9; i++) begin
            i_read = tbl[i].i_rd; d_read = tbl[i].d_rd; d_write = tbl[i].d_wr; m_waitrequest = tbl[i].m_wt;
            @(negedge clk);
            chk($sformatf("vec%0d", i), 160'({owner, m_read, m_write, i_waitrequest, d_waitrequest}),
                160'({tbl[i].owner, tbl[i].m_rd, tbl[i].m_wr, tbl[i].i_wt, tbl[i].d_wt}));
            if (tbl[i].owner == 2'd2)
                chk($sformatf("vec%0d_wdata", i), 160'({m_address, m_writedata, m_byteenable}), 160'({DA, WD, BE}));
            to_pos();
        end

        // D read stalled three cycles while I waits; I follows directly.
        clear_inputs();
        d_read = 1'b1; m_waitrequest = 1'b1;
        start_reset();
        to_pos();
        i_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d", k), 160'({owner, d_waitrequest, i_waitrequest, timeout_err}),
                160'({2'd2, 1'b1, 1'b1, 1'b0}));
            to_pos();
        end
        m_waitrequest = 1'b0;
        @(negedge clk);
        chk("stall_done", 160'({d_waitrequest, d_readdata, timeout_err}), 160'({1'b0, RD, 1'b0}));
        to_pos();
        @(negedge clk);
        chk("stall_then_i", 160'(owner), 160'(2'd1));

        // Stuck slave: abort on the fourth stalled cycle.
        clear_inputs();
        d_read = 1'b1; m_waitrequest = 1'b1; m_readdata = 32'hDEAD_BEEF;
        start_reset();
        to_pos();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("to_pre%0d", k), 160'({timeout_err, d_waitrequest, m_read}), 160'({1'b0, 1'b1, 1'b1}));
            to_pos();
        end
        @(negedge clk);
        chk("to_abort", 160'({timeout_err, d_waitrequest, d_readdata, m_read}), 160'({1'b1, 1'b0, 32'h0, 1'b0}));
        to_pos();
        @(negedge clk);
        chk("to_after", 160'({owner, timeout_err}), 160'({2'd0, 1'b0}));

        // Asynchronous reset between edges during a D write.
        clear_inputs();
        d_write = 1'b1; m_waitrequest = 1'b1;
        start_reset();
        to_pos();
        @(negedge clk);
        chk("async_pre", 160'({owner, m_write}), 160'({2'd2, 1'b1}));
        #2 reset = 1'b0;
        #1;
        chk("async_reset", 160'({m_write, d_waitrequest, owner}), 160'({1'b0, 1'b1, 2'd0}));

        // Randomized traffic against the reference model.
        clear_inputs();
        start_reset();
        mo = 0; ml = 2; ms = 0;
        for (int k = 0; k < 3000; k++) begin
            i_read = ($urandom_range(0, 9) < 7);
            d_read = ($urandom_range(0, 9) < 4);
            d_write = ($urandom_range(0, 9) < 3);
            m_waitrequest = ($urandom_range(0, 3) != 0);
            i_address = $urandom; d_address = $urandom;
            d_writedata = $urandom; m_readdata = $urandom;
            d_byteenable = 4'($urandom_range(0, 15));
            @(negedge clk);
            model_eval();
            chk($sformatf("rand_cyc%0d", k), 160'(actual()), 160'(e));
            @(posedge clk);
            mo = nmo; ml = nml; ms = nms;
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of the MIPS CPU between two requesters: an instruction-fetch master (I, read-only) and a load/store master (D).
- Registered round-robin grant; the bus is held by the owner until the slave accepts (waitrequest low).
- A watchdog aborts transfers that the slave stalls beyond MAX_WAIT cycles.
- Sits between the CPU core's fetch/memory stages and the external bus (address/read/write/writedata/byteenable/readdata/waitrequest).

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width (byteenable width = DATA_W/8)
MAX_WAIT, 255, max consecutive stalled cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
i_address  in  ADDR_W  fetch address
i_read  in  1  fetch request
i_waitrequest  out  1  stall to fetch master
i_readdata  out  DATA_W  fetch data
d_address  in  ADDR_W  load/store address
d_read  in  1  load request
d_write  in  1  store request
d_writedata  in  DATA_W  store data
d_byteenable  in  DATA_W/8  load/store lanes
d_waitrequest  out  1  stall to data master
d_readdata  out  DATA_W  load data
m_address  out  ADDR_W  bus address
m_read  out  1  bus read
m_write  out  1  bus write
m_writedata  out  DATA_W  bus write data
m_byteenable  out  DATA_W/8  bus lanes
m_waitrequest  in  1  slave stall
m_readdata  in  DATA_W  slave read data, valid in the cycle m_waitrequest=0
owner  out  2  current grant: 0 none, 1 I, 2 D
timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, immediate): state IDLE, owner=0, last=D (first tie goes to I), wait counter 0.
- Reset values: m_read=m_write=0; m_address, m_writedata, m_byteenable=0; i_/d_waitrequest=1; i_/d_readdata=0; timeout_err=0.
- Reset mid-transfer abandons the transfer; no completion is reported.
- States: IDLE, GNT_I, GNT_D.
- Requests: rq_i=i_read; rq_d=d_read|d_write.
- IDLE: if only one master requests, grant it. If both request, grant the one != last. Grant is registered; bus is driven from the next cycle, so minimum request-to-bus latency is 1 cycle.
- GNT_I: m_address=i_address, m_read=1, m_write=0, m_byteenable=all ones, m_writedata=0. i_waitrequest=m_waitrequest; i_readdata=m_readdata.
- GNT_D: m_* passthrough from d_*. If d_read and d_write are both high, the write wins and m_read=0. d_waitrequest=m_waitrequest; d_readdata=m_readdata.
- Non-owner: waitrequest=1, readdata=0, always. m_* are 0 in IDLE (combinational mux on state).
- Completion: granted, request high, m_waitrequest=0. That cycle:
  - last := owner.
  - Next state = the other master's grant if it requests, else IDLE.
  - The completing master is excluded, because its request that cycle is the old one. A master re-requesting back-to-back therefore sees one IDLE bubble unless the other master is served between.
- Owner drops its request while granted (protocol violation): IDLE next cycle; last unchanged; no pulse.
- Watchdog (MAX_WAIT>0):
  - Counter clears on grant. It increments on each granted cycle with m_waitrequest=1.
  - When the counter would reach MAX_WAIT: owner sees waitrequest=0 with readdata=0, m_read/m_write are forced 0 that cycle, and timeout_err=1 for that cycle. Then next state = IDLE and last := owner.
  - Counter width: $clog2(MAX_WAIT+1); it saturates, never wraps.
- A slave that completes in the same cycle the counter hits MAX_WAIT is a normal completion with no error (completion has priority).
- owner reflects the state register.

Decomposition:
- Package mips_bus_pkg:
  - owner_t enum {OWN_NONE=0, OWN_I=1, OWN_D=2}
  - arb_state_t {IDLE, GNT_I, GNT_D}
  - localparams BUS_ADDR_W=32, BUS_DATA_W=32
- One sub-module: mips_bus_watchdog (counter with clear/enable/expire, parameter MAX_WAIT).
- Arbitration FSM and muxing live in the top module.

Test Plan:
- Reset: hold reset=0 with i_read=1 -> m_read=0, i_waitrequest=1, owner=0. Release -> cycle+1: owner=1, m_read=1, m_address=i_address.
- Single read: i_read=1, i_address=32'h0000_0010, slave waitrequest=0 with readdata=32'hCAFE_F00D -> i_readdata=32'hCAFE_F00D and i_waitrequest=0 on the granted cycle. Next cycle owner=0.
- Contention: i_read and d_write both held from reset with 0-wait slave -> grants alternate I, D, I, D. d_write transfer shows m_writedata=d_writedata and m_byteenable=d_byteenable (e.g. 4'b0011).
- Stall: slave holds waitrequest=1 for 3 cycles on a D read -> d_waitrequest=1 for 3 cycles then 0. The I request stays stalled and I is granted on the completion cycle's next edge.
- Timeout: MAX_WAIT=4, slave waitrequest stuck 1 -> on the 4th stalled cycle timeout_err=1 for one cycle, d_waitrequest=0, d_readdata=0, m_read=0. Next cycle owner=0.
- Async reset mid-transfer: reset=0 between clock edges during GNT_D -> m_write drops immediately, d_waitrequest=1, owner=0.
